serial_alu_ctrl: RTL and testbench

- Bit-serial sequencer that drives a single external 1-bit ALU slice, one bit per clock, LSB first, to compute a WIDTH-bit AND/OR/ADD/SUB/SLT.
- Owns operand shift registers, the carry register and result assembly.
- Produces the slice's a/b/cin/inv/less/signal inputs and consumes its out/cout.
- Sits in the execution unit as the area-minimal alternative to a 32-slice ripple array.

---
 rtl/serial_alu_pkg.sv | 27 ++
 rtl/serial_alu_shreg.sv | 42 ++++
 rtl/serial_alu_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_serial_alu_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_alu_pkg.sv
// Shared definitions for the bit-serial ALU sequencer: function codes, FSM states
// and the default bit-index counter width.
// No logic; imported by serial_alu_shreg and serial_alu_ctrl.
package serial_alu_pkg;

    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_CNT_W = $clog2(DEF_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PASS1 = 2'd1,
        ST_PASS2 = 2'd2,
        ST_FIN   = 2'd3
    } state_e;

    function automatic logic funct_legal(input logic [5:0] f);
        return (f == FN_AND) || (f == FN_OR) || (f == FN_ADD) ||
               (f == FN_SUB) || (f == FN_SLT);
    endfunction

endpackage

// File: rtl/serial_alu_shreg.sv
// WIDTH-bit load / shift-right register; serial data enters at the MSB.
// Latency: load or shift takes effect at the next clock edge; load wins over shift.
// No backpressure: the owner decides every cycle whether to load or shift.
// Ports: clk, rst_n, load_i/load_dat_i (parallel load), shift_i/ser_i (shift in at MSB),
//        q_o (register contents).
module serial_alu_shreg
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_dat_i,
    input  logic             shift_i,
    input  logic             ser_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load_i) begin
            sr_d = load_dat_i;
        end else if (shift_i) begin
            sr_d = {ser_i, sr_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign q_o = sr_q;

endmodule

// File: rtl/serial_alu_ctrl.sv
// Bit-serial sequencer driving one external 1-bit ALU slice, LSB first (AND/OR/ADD/SUB/SLT).
// Latency: done WIDTH+1 cycles after start (SLT 2*WIDTH+1, illegal funct 1 cycle).
// No backpressure: start is only sampled in IDLE and ignored while busy or in FIN.
// Ports: start/a_in/b_in/funct request; busy/done/result/carry/zero/err status;
//        slc_* drive the slice, slc_out/slc_cout return from it.
// Optional: define SERIAL_ALU_OVF_EN to add the ovf output (signed overflow of ADD/SUB).
module serial_alu_ctrl
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [5:0]       funct,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             err,
    output logic             slc_a,
    output logic             slc_b,
    output logic             slc_cin,
    output logic             slc_inv,
    output logic             slc_less,
    output logic [5:0]       slc_signal,
    input  logic             slc_out,
`ifdef SERIAL_ALU_OVF_EN
    input  logic             slc_cout,
    output logic             ovf
`else
    input  logic             slc_cout
`endif
);

    localparam int CNT_W = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0]       fn_q;
    logic             chain_q;     // carry out of the previous bit
    logic             set_q;       // SLT outcome, fed into bit 0 of PASS2
    logic             carry_q;
    logic             zero_q;
    logic             err_q;
    logic             done_q;
    logic             busy_q;

    logic             accept;
    logic             is_sub;
    logic             is_addsub;
    logic             first_bit;
    logic             last_bit;
    logic             shift_op;
    logic             shift_res;
    logic [WIDTH-1:0] a_sr, b_sr, res_sr;
    logic [WIDTH-1:0] res_shifted;
    logic             unused_opbits;

    assign accept    = (state_q == ST_IDLE) && start;
    assign is_sub    = (fn_q == FN_SUB) || (fn_q == FN_SLT);
    assign is_addsub = (fn_q == FN_ADD) || (fn_q == FN_SUB);
    assign first_bit = (cnt_q == '0);
    assign last_bit  = (cnt_q == CNT_W'(WIDTH - 1));

    // Value the result register takes at this edge when shifting; zero is
    // registered from it so it lines up with the final result.
    assign res_shifted = {slc_out, res_sr[WIDTH-1:1]};

    // Only the LSB of each operand register feeds the slice.
    assign unused_opbits = ^{a_sr[WIDTH-1:1], b_sr[WIDTH-1:1]};

    serial_alu_shreg #(.WIDTH(WIDTH)) u_a_sr (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (accept),
        .load_dat_i (a_in),
        .shift_i    (shift_op),
        .ser_i      (1'b0),
        .q_o        (a_sr)
    );

    serial_alu_shreg #(.WIDTH(WIDTH)) u_b_sr (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (accept),
        .load_dat_i (b_in),
        .shift_i    (shift_op),
        .ser_i      (1'b0),
        .q_o        (b_sr)
    );

    // Cleared on every accepted start so an illegal funct reports result 0.
    serial_alu_shreg #(.WIDTH(WIDTH)) u_res_sr (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (accept),
        .load_dat_i ('0),
        .shift_i    (shift_res),
        .ser_i      (slc_out),
        .q_o        (res_sr)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_op   = 1'b0;
        shift_res  = 1'b0;
        slc_a      = 1'b0;
        slc_b      = 1'b0;
        slc_cin    = 1'b0;
        slc_inv    = 1'b0;
        slc_less   = 1'b0;
        slc_signal = 6'b000000;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cnt_d   = '0;
                    state_d = funct_legal(funct) ? ST_PASS1 : ST_FIN;
                end
            end
            ST_PASS1: begin
                slc_a      = a_sr[0];
                slc_b      = b_sr[0];
                slc_inv    = is_sub;
                slc_cin    = first_bit ? is_sub : chain_q;
                // SLT first computes A-B to derive its set bit.
                slc_signal = (fn_q == FN_SLT) ? FN_SUB : fn_q;
                shift_op   = 1'b1;
                shift_res  = 1'b1;
                cnt_d      = cnt_q + CNT_W'(1);
                if (last_bit) begin
                    cnt_d   = '0;
                    state_d = (fn_q == FN_SLT) ? ST_PASS2 : ST_FIN;
                end
            end
            ST_PASS2: begin
                slc_signal = FN_SLT;
                slc_less   = first_bit & set_q;
                shift_res  = 1'b1;
                cnt_d      = cnt_q + CNT_W'(1);
                if (last_bit) begin
                    cnt_d   = '0;
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            fn_q    <= '0;
            chain_q <= 1'b0;
            set_q   <= 1'b0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= (state_d == ST_FIN);
            busy_q  <= (state_d == ST_PASS1) || (state_d == ST_PASS2);
            err_q   <= (state_d == ST_FIN) && (state_q == ST_IDLE);
            if (accept) begin
                fn_q    <= funct;
                chain_q <= 1'b0;
                set_q   <= 1'b0;
                carry_q <= 1'b0;
            end
            if (state_q == ST_PASS1) begin
                chain_q <= slc_cout;
                if (last_bit) begin
                    if (is_addsub) begin
                        carry_q <= slc_cout;
                    end
                    // Sign of the difference corrected by signed overflow.
                    if (fn_q == FN_SLT) begin
                        set_q <= slc_out ^ (slc_cin ^ slc_cout);
                    end
                end
            end
            if (state_d == ST_FIN) begin
                zero_q <= (state_q == ST_IDLE) ? 1'b1 : (res_shifted == '0);
            end
        end
    end

`ifdef SERIAL_ALU_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (accept) begin
            ovf_q <= 1'b0;
        end else if ((state_q == ST_PASS1) && last_bit && is_addsub) begin
            ovf_q <= slc_cin ^ slc_cout;
        end
    end

    assign ovf = ovf_q;
`endif

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = res_sr;
    assign carry  = carry_q;
    assign zero   = zero_q;
    assign err    = err_q;

endmodule

// File: tb/tb_serial_alu_ctrl.sv
module tb_serial_alu_ctrl;
    import serial_alu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a_in, b_in;
    logic [5:0]   funct;
    logic         busy, done, carry, zero, err;
    logic [W-1:0] result;
    logic         slc_a, slc_b, slc_cin, slc_inv, slc_less, slc_out, slc_cout;
    logic [5:0]   slc_signal;
    logic         ovf;
    logic         bb;

    always #5 clk = ~clk;

    serial_alu_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a_in       (a_in),
        .b_in       (b_in),
        .funct      (funct),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .carry      (carry),
        .zero       (zero),
        .err        (err),
        .slc_a      (slc_a),
        .slc_b      (slc_b),
        .slc_cin    (slc_cin),
        .slc_inv    (slc_inv),
        .slc_less   (slc_less),
        .slc_signal (slc_signal),
        .slc_out    (slc_out),
`ifdef SERIAL_ALU_OVF_EN
        .slc_cout   (slc_cout),
        .ovf        (ovf)
`else
        .slc_cout   (slc_cout)
`endif
    );

`ifndef SERIAL_ALU_OVF_EN
    assign ovf = 1'b0;
`endif

    // Behavioural 1-bit ALU slice.
    always_comb begin
        bb       = slc_b ^ slc_inv;
        slc_cout = (slc_a & bb) | (slc_a & slc_cin) | (bb & slc_cin);
        slc_out  = 1'b0;
        case (slc_signal)
            FN_AND:         slc_out = slc_a & bb;
            FN_OR:          slc_out = slc_a | bb;
            FN_ADD, FN_SUB: slc_out = slc_a ^ bb ^ slc_cin;
            FN_SLT:         slc_out = slc_less;
            default:        slc_out = 1'b0;
        endcase
    end

    typedef struct {
        logic [W-1:0] res;
        logic         carry;
        logic         zero;
        logic         err;
        logic         ovf;
        int           due;
    } sb_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [5:0]   f;
        logic [W-1:0] res;
        logic         carry;
        logic         zero;
        logic         err;
    } vec_t;

    sb_t  sb[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    logic busy_seen;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic sb_t ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [5:0] f);
        sb_t          e;
        logic [W:0]   s;
        e.res = '0; e.carry = 1'b0; e.err = 1'b0; e.ovf = 1'b0; e.due = W;
        case (f)
            FN_AND: e.res = a & b;
            FN_OR:  e.res = a | b;
            FN_ADD: begin
                s = {1'b0, a} + {1'b0, b};
                e.res = s[W-1:0]; e.carry = s[W];
                e.ovf = (a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]);
            end
            FN_SUB: begin
                s = {1'b0, a} + {1'b0, ~b} + 1;
                e.res = s[W-1:0]; e.carry = s[W];
                e.ovf = (a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]);
            end
            FN_SLT: begin
                e.res = ($signed(a) < $signed(b)) ? 1 : 0;
                e.due = 2 * W;
            end
            default: begin
                e.err = 1'b1;
                e.due = 0;
            end
        endcase
        e.zero = (e.res == '0);
        return e;
    endfunction

    // Drive one request; leaves the bench at the negedge of slice bit 0.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [5:0] f,
                         input sb_t e);
        sb_t q;
        @(negedge clk);
        a_in = a; b_in = b; funct = f; start = 1'b1;
        q = e;
        q.due = cyc + 1 + e.due;
        sb.push_back(q);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (sb.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL timeout: %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (busy) busy_seen = 1'b1;
            if (done) begin
                chk("done_expected", (sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    sb_t e;
                    e = sb.pop_front();
                    chk("done_cycle", cyc, e.due);
                    chk("result", result, e.res);
                    chk("carry", carry, e.carry);
                    chk("zero", zero, e.zero);
                    chk("err", err, e.err);
                    chk("busy_at_done", busy, 0);
`ifdef SERIAL_ALU_OVF_EN
                    chk("ovf", ovf, e.ovf);
`endif
                end
            end else begin
                if (err) chk("err_without_done", err, 0);
            end
        end
    end

    task automatic chk_all_zero(input string name);
        chk(name, {busy, done, result, carry, zero, err, ovf,
                   slc_a, slc_b, slc_cin, slc_inv, slc_less, slc_signal}, 0);
    endtask

    vec_t vecs[10];

    initial begin
        sb_t e;
        logic [5:0] fl[5];

        vecs[0] = '{32'h0000_0005, 32'h0000_0003, FN_ADD, 32'h0000_0008, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{32'h0000_0003, 32'h0000_0003, FN_SUB, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{32'h8000_0000, 32'h7FFF_FFFF, FN_SLT, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{32'h0000_0005, 32'hFFFF_FFFF, FN_SLT, 32'h0000_0000, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{32'hF0F0_F0F0, 32'hFF00_FF00, FN_AND, 32'hF000_F000, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{32'hF0F0_F0F0, 32'hFF00_FF00, FN_OR,  32'hFFF0_FFF0, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{32'hFFFF_FFFF, 32'h0000_0001, FN_ADD, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
        vecs[7] = '{32'h0000_0000, 32'h0000_0001, FN_SUB, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{32'h0000_1234, 32'h0000_5678, 6'b000000, 32'h0000_0000, 1'b0, 1'b1, 1'b1};
        vecs[9] = '{32'h7FFF_FFFF, 32'h0000_0001, FN_ADD, 32'h8000_0000, 1'b0, 1'b0, 1'b0};
        fl[0] = FN_AND; fl[1] = FN_OR; fl[2] = FN_ADD; fl[3] = FN_SUB; fl[4] = FN_SLT;

        rst_n = 1'b0; start = 1'b0; a_in = '0; b_in = '0; funct = '0; busy_seen = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset_state");
        rst_n = 1'b1;

        // Table-driven vectors; ovf comes from the arithmetic model.
        for (int i = 0; i < 10; i++) begin
            e = ref_op(vecs[i].a, vecs[i].b, vecs[i].f);
            e.res = vecs[i].res; e.carry = vecs[i].carry;
            e.zero = vecs[i].zero; e.err = vecs[i].err;
            issue(vecs[i].a, vecs[i].b, vecs[i].f, e);
            wait_idle(3 * W);
        end

        // Random legal operations against the model.
        for (int i = 0; i < 8; i++) begin
            logic [W-1:0] ra, rb;
            logic [5:0]   rf;
            ra = $urandom; rb = $urandom; rf = fl[$urandom_range(0, 4)];
            issue(ra, rb, rf, ref_op(ra, rb, rf));
            wait_idle(3 * W);
        end

        // SUB: inverted B and carry-in 1 at bit 0, busy already high.
        issue(32'd3, 32'd3, FN_SUB, ref_op(32'd3, 32'd3, FN_SUB));
        chk("sub_bit0_inv", slc_inv, 1);
        chk("sub_bit0_cin", slc_cin, 1);
        chk("sub_busy", busy, 1);
        wait_idle(3 * W);

        // SLT overflow case: PASS1 runs as SUB, PASS2 feeds set into bit 0.
        issue(32'h8000_0000, 32'h7FFF_FFFF, FN_SLT, ref_op(32'h8000_0000, 32'h7FFF_FFFF, FN_SLT));
        chk("slt_p1_signal", slc_signal, FN_SUB);
        chk("slt_p1_inv", slc_inv, 1);
        repeat (W) @(negedge clk);
        chk("slt_p2_signal", slc_signal, FN_SLT);
        chk("slt_p2_less", slc_less, 1);
        @(negedge clk);
        chk("slt_p2_less_bit1", slc_less, 0);
        wait_idle(3 * W);

        // Illegal funct: busy never rises.
        busy_seen = 1'b0;
        issue(32'hDEAD_BEEF, 32'h1, 6'b000000, ref_op(32'hDEAD_BEEF, 32'h1, 6'b000000));
        wait_idle(3 * W);
        chk("illegal_busy_seen", busy_seen, 0);

        // Start pulse during an ADD is ignored.
        issue(32'd100, 32'd23, FN_ADD, ref_op(32'd100, 32'd23, FN_ADD));
        repeat (5) @(negedge clk);
        a_in = 32'hFFFF; b_in = 32'hFFFF; funct = FN_OR; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle(3 * W);
        repeat (W + 4) @(negedge clk);

        // Reset at bit 10 of an ADD aborts it with no done pulse.
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, FN_ADD, ref_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, FN_ADD));
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_all_zero("abort_outputs");
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 4) @(negedge clk);
        chk("abort_no_done", done, 0);
        issue(32'h0000_0005, 32'h0000_0003, FN_ADD, ref_op(32'd5, 32'd3, FN_ADD));
        wait_idle(3 * W);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
